// File: rtl/yuv422_fb_pkg.sv
// Shared types and helpers for the YUV422 frame-buffer scan-out path.
// Used by yuv422_fb_reader; see that file for the YUV422_FB_READER_TPG_EN option.
package yuv422_fb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } fb_state_e;

  typedef struct packed {
    logic [7:0] c;
    logic [7:0] y;
  } yuv422_pix_t;

  // Byte positions inside a 32-bit BRAM word
  localparam int unsigned Y0 = 0;
  localparam int unsigned CB = 1;
  localparam int unsigned Y1 = 2;
  localparam int unsigned CR = 3;

  localparam logic [7:0] TPG_CHROMA = 8'h80;

  // Even half -> {Cb,Y0}, odd half -> {Cr,Y1}
  function automatic yuv422_pix_t unpack(input logic [31:0] word, input logic half);
    yuv422_pix_t p;
    if (half) begin
      p.c = word[8*CR +: 8];
      p.y = word[8*Y1 +: 8];
    end else begin
      p.c = word[8*CB +: 8];
      p.y = word[8*Y0 +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/yuv422_fb_reader.sv
// Frame-buffer scan-out: walks BRAM words and streams two YUV422 pixels per word.
// Define YUV422_FB_READER_TPG_EN to add tpg_i, which swaps memory pixels for a grey ramp.
module yuv422_fb_reader
  import yuv422_fb_pkg::*;
#(
  parameter int unsigned H_RES = 1920,
  parameter int unsigned V_RES = 1080,
  parameter int unsigned LINES = H_RES * V_RES / 2,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     frame_start_i,
  output logic [$clog2(LINES)-1:0] rd_addr_o,
  input  logic [DW-1:0]            rd_d_i,
`ifdef YUV422_FB_READER_TPG_EN
  input  logic                     tpg_i,
`endif
  output logic [15:0]              pix_o,
  output logic                     pix_valid_o,
  input  logic                     pix_ready_i,
  output logic                     pix_sof_o,
  output logic                     pix_eol_o,
  output logic                     busy_o
);

  localparam int unsigned AW = $clog2(LINES);
  localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  fb_state_e   state_q, state_d;
  logic [AW-1:0] ptr_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          half_q;
  logic [DW-1:0] word_q;

  logic        valid;
  logic        accept;
  logic        last_x;
  logic        last_y;
  logic        frame_done;
  yuv422_pix_t mem_pix;

  assign valid      = (state_q == STREAM);
  assign accept     = valid && pix_ready_i;
  assign last_x     = (x_q == XW'(H_RES - 1));
  assign last_y     = (y_q == YW'(V_RES - 1));
  assign frame_done = accept && half_q && last_x && last_y;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: back-to-back frames skip IDLE when the start pulse meets the final accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start_i) state_d = LOAD;
      LOAD:    state_d = STREAM;
      STREAM:  if (frame_done) state_d = frame_start_i ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      half_q <= 1'b0;
      word_q <= '0;
    end else if (state_q == LOAD) begin
      word_q <= rd_d_i;
      ptr_q  <= AW'(1);
      half_q <= 1'b0;
    end else if (accept) begin
      half_q <= ~half_q;
      if (last_x) begin
        x_q <= '0;
        y_q <= last_y ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
      // Odd pixel consumed: refill from the pointer; saturate so ptr stays within the BRAM
      if (half_q) begin
        if (frame_done) begin
          ptr_q <= '0;
        end else begin
          word_q <= rd_d_i;
          ptr_q  <= (ptr_q == AW'(LINES - 1)) ? ptr_q : ptr_q + AW'(1);
        end
      end
    end
  end

  assign mem_pix     = unpack(word_q, half_q);
  assign rd_addr_o   = ptr_q;
  assign pix_valid_o = valid;
  assign busy_o      = (state_q != IDLE);
  assign pix_sof_o   = valid && (x_q == '0) && (y_q == '0);
  assign pix_eol_o   = valid && last_x;

  always_comb begin
    pix_o = '0;
    if (valid) begin
      pix_o = mem_pix;
`ifdef YUV422_FB_READER_TPG_EN
      if (tpg_i) pix_o = {TPG_CHROMA, 8'(x_q)};
`endif
    end
  end

endmodule

// File: tb/tb_yuv422_fb_reader.sv
// Randomized bench for yuv422_fb_reader on a 4x2 frame against a pixel-list reference model.
module tb_yuv422_fb_reader;

  localparam int unsigned H_RES  = 4;
  localparam int unsigned V_RES  = 2;
  localparam int unsigned LINES  = H_RES * V_RES / 2;
  localparam int unsigned NPIX   = H_RES * V_RES;
  localparam int          BUDGET = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [1:0]  rd_addr;
  logic [31:0] rd_d;
  logic        tpg;
  logic [15:0] pix;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_eol;
  logic        busy;

  logic [31:0] mem [LINES];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rd_d = mem[rd_addr];

  yuv422_fb_reader #(
    .H_RES(H_RES),
    .V_RES(V_RES),
    .LINES(LINES),
    .DW   (32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .frame_start_i(frame_start),
    .rd_addr_o    (rd_addr),
    .rd_d_i       (rd_d),
`ifdef YUV422_FB_READER_TPG_EN
    .tpg_i        (tpg),
`endif
    .pix_o        (pix),
    .pix_valid_o  (pix_valid),
    .pix_ready_i  (pix_ready),
    .pix_sof_o    (pix_sof),
    .pix_eol_o    (pix_eol),
    .busy_o       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: pixel p lives in word p/2, low half first
  function automatic logic [15:0] exp_pix(input int p, input bit use_tpg);
    logic [31:0] w;
    w = mem[p / 2];
    if (use_tpg) return {8'h80, 8'(p % H_RES)};
    return (p % 2 == 1) ? w[31:16] : w[15:0];
  endfunction

  function automatic int exp_addr(input int p);
    int a;
    a = p / 2 + 1;
    if (a > LINES - 1) a = LINES - 1;
    return a;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_pix"},   32'(pix),       32'd0);
    check({tag, "_sof"},   32'(pix_sof),   32'd0);
    check({tag, "_eol"},   32'(pix_eol),   32'd0);
    check({tag, "_addr"},  32'(rd_addr),   32'd0);
  endtask

  // Pulse frame_start for one edge, then confirm the LOAD cycle
  task automatic start_frame();
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    check("load_busy",  32'(busy),      32'd1);
    check("load_valid", 32'(pix_valid), 32'd0);
    check("load_addr",  32'(rd_addr),   32'd0);
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random with stray frame_start pulses
  task automatic stream_frame(input int ready_mode, input bit b2b, input int abort_at,
                              input bit use_tpg);
    int idx = 0;
    int cyc = 0;
    bit aborted = 1'b0;
    while (idx < NPIX && cyc < BUDGET) begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      frame_start = 1'b0;
      if (ready_mode == 2 && idx < NPIX - 1) frame_start = ($urandom_range(0, 7) == 0);
      if (b2b && idx == NPIX - 1 && pix_ready) frame_start = 1'b1;
      @(negedge clk);
      check($sformatf("valid_p%0d", idx), 32'(pix_valid), 32'd1);
      check($sformatf("busy_p%0d", idx),  32'(busy),      32'd1);
      check($sformatf("pix_p%0d", idx),   32'(pix),       32'(exp_pix(idx, use_tpg)));
      check($sformatf("sof_p%0d", idx),   32'(pix_sof),   32'(idx == 0));
      check($sformatf("eol_p%0d", idx),   32'(pix_eol),   32'(idx % H_RES == H_RES - 1));
      check($sformatf("addr_p%0d", idx),  32'(rd_addr),   32'(exp_addr(idx)));
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1;
        #1;
        check_quiet("abort");
        aborted = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        frame_start = 1'b0;
        break;
      end
      if (pix_ready) idx++;
      cyc++;
    end
    check("frame_within_budget", 32'(cyc < BUDGET), 32'd1);
    if (!aborted) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      pix_ready   = 1'b0;
      @(negedge clk);
      if (b2b) begin
        check("b2b_load_busy",  32'(busy),      32'd1);
        check("b2b_load_valid", 32'(pix_valid), 32'd0);
        check("b2b_load_addr",  32'(rd_addr),   32'd0);
      end else begin
        check_quiet("end");
      end
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < int'(LINES); i++) mem[i] = $urandom();
  endtask

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    pix_ready   = 1'b0;
    tpg         = 1'b0;
    fill_mem();
    mem[0] = 32'h80104020;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic unpack and full frame at full rate
    start_frame();
    stream_frame(0, 1'b0, -1, 1'b0);

    // Back-pressure pattern
    fill_mem();
    start_frame();
    stream_frame(1, 1'b0, -1, 1'b0);

    // Random ready with ignored frame_start pulses
    for (int f = 0; f < 4; f++) begin
      fill_mem();
      start_frame();
      stream_frame(2, 1'b0, -1, 1'b0);
    end

    // Back-to-back frames
    fill_mem();
    mem[0] = 32'h80104020;
    start_frame();
    stream_frame(0, 1'b1, -1, 1'b0);
    stream_frame(2, 1'b0, -1, 1'b0);

    // Mid-frame reset then restart from word 0
    fill_mem();
    start_frame();
    stream_frame(0, 1'b0, 5, 1'b0);
    start_frame();
    stream_frame(0, 1'b0, -1, 1'b0);

`ifdef YUV422_FB_READER_TPG_EN
    tpg = 1'b1;
    fill_mem();
    start_frame();
    stream_frame(0, 1'b0, -1, 1'b1);
    tpg = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
